// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the hazard sequencer and its compare sub-block.
//   hs_state_e : sequencer FSM encoding (run / drain / halt)
//   RegZero    : index of the hard-wired zero register, which never creates a dependency
package hazard_sequencer_pkg;

    typedef enum logic [1:0] {
        HsRun   = 2'd0,
        HsDrain = 2'd1,
        HsHalt  = 2'd2
    } hs_state_e;

    localparam int unsigned RegZero = 0;

endpackage

// File: rtl/hazard_match.sv
// Combinational dependency compare between the instruction in ID and producers in EX/MEM.
// Ports:
//   id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch : ID consumer description
//   ex_wb_en, ex_mem_r, ex_rd                         : EX producer description
//   mem_wb_en, mem_mem_r, mem_rd                      : MEM producer description
//   lu : load-use hazard (load in EX feeds ID)
//   br : branch-operand hazard (ID compare needs a value not yet available)
module hazard_match
    import hazard_sequencer_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_branch,
    input  logic             ex_wb_en,
    input  logic             ex_mem_r,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_wb_en,
    input  logic             mem_mem_r,
    input  logic [REG_W-1:0] mem_rd,
    output logic             lu,
    output logic             br
);

    function automatic logic m(input logic [REG_W-1:0] x, input logic [REG_W-1:0] rd);
        return (x == rd) && (rd != REG_W'(RegZero));
    endfunction

    logic ex_dep;
    logic mem_dep;
    logic mem_load;

    always_comb begin
        ex_dep  = (id_use_rs && m(id_rs, ex_rd)) || (id_use_rt && m(id_rt, ex_rd));
        mem_dep = (id_use_rs && m(id_rs, mem_rd)) || (id_use_rt && m(id_rt, mem_rd));
        // A load in MEM always writes; qualifying with wb_en ignores squashed slots.
        mem_load = mem_mem_r && mem_wb_en;
        lu = ex_mem_r && ex_dep;
        // ALU results in MEM are forwarded to the ID comparator; only loads still block.
        br = id_is_branch && ((ex_wb_en && ex_dep) || (mem_load && mem_dep));
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencer for the 5-stage core: stalls on load-use / branch-operand hazards,
// flushes IF/ID on taken control transfers, drains and halts on terminate, and counts
// stall cycles (saturating) for bring-up.
// Ports:
//   clk, rst (sync, active-high)
//   id_*, ex_*, mem_*            : dependency information from ID/EX/MEM
//   branch_taken, jump_taken     : control transfer from the decoder (ignored while stalled)
//   terminate                    : halt request from the decoder (ignored while stalled)
//   harzard, pc_en, if_id_en, if_id_flush, id_ex_bubble : pipeline control
//   halted                       : core frozen
//   stall_cycles                 : saturating stall counter
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int unsigned REG_W     = 5,
    parameter int unsigned DRAIN_CYC = 3,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_branch,
    input  logic             ex_wb_en,
    input  logic             ex_mem_r,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_wb_en,
    input  logic             mem_mem_r,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             branch_taken,
    input  logic             jump_taken,
    input  logic             terminate,
    output logic             harzard,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned DrainW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    hs_state_e         state_q, state_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lu, br, stall;

    hazard_match #(
        .REG_W (REG_W)
    ) u_match (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_is_branch (id_is_branch),
        .ex_wb_en     (ex_wb_en),
        .ex_mem_r     (ex_mem_r),
        .ex_rd        (ex_rd),
        .mem_wb_en    (mem_wb_en),
        .mem_mem_r    (mem_mem_r),
        .mem_rd       (mem_rd),
        .lu           (lu),
        .br           (br)
    );

    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        cnt_d        = cnt_q;
        harzard      = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        halted       = 1'b0;
        stall        = (lu || br) && (state_q == HsRun) && !rst;

        // Reset forces the free-running outputs regardless of the registered state.
        if (!rst) begin
            case (state_q)
                HsRun: begin
                    if (stall) begin
                        harzard      = 1'b1;
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (terminate) begin
                        // Terminate outranks a same-cycle branch; the flush is wanted anyway.
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                        state_d     = HsDrain;
                        drain_d     = DrainW'(DRAIN_CYC - 1);
                    end else begin
                        if_id_flush = branch_taken || jump_taken;
                    end
                end
                HsDrain: begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (drain_q == '0) begin
                        state_d = HsHalt;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
                HsHalt: begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                    halted       = 1'b1;
                end
                default: begin
                    state_d = HsRun;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HsRun;
            drain_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: a default instance plus a CNT_W=4 instance sharing
// the same stimulus to observe counter saturation.
module tb_hazard_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       id_use_rs, id_use_rt, id_is_branch;
    logic       ex_wb_en, ex_mem_r, mem_wb_en, mem_mem_r;
    logic       branch_taken, jump_taken, terminate;

    logic        harzard, pc_en, if_id_en, if_id_flush, id_ex_bubble, halted;
    logic [31:0] stall_cycles;
    logic        s_harzard, s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_bubble, s_halted;
    logic [3:0]  s_stall_cycles;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    hazard_sequencer dut (
        .clk (clk), .rst (rst),
        .id_rs (id_rs), .id_rt (id_rt), .id_use_rs (id_use_rs), .id_use_rt (id_use_rt),
        .id_is_branch (id_is_branch), .ex_wb_en (ex_wb_en), .ex_mem_r (ex_mem_r),
        .ex_rd (ex_rd), .mem_wb_en (mem_wb_en), .mem_mem_r (mem_mem_r), .mem_rd (mem_rd),
        .branch_taken (branch_taken), .jump_taken (jump_taken), .terminate (terminate),
        .harzard (harzard), .pc_en (pc_en), .if_id_en (if_id_en),
        .if_id_flush (if_id_flush), .id_ex_bubble (id_ex_bubble), .halted (halted),
        .stall_cycles (stall_cycles)
    );

    hazard_sequencer #(.CNT_W (4)) dut_sat (
        .clk (clk), .rst (rst),
        .id_rs (id_rs), .id_rt (id_rt), .id_use_rs (id_use_rs), .id_use_rt (id_use_rt),
        .id_is_branch (id_is_branch), .ex_wb_en (ex_wb_en), .ex_mem_r (ex_mem_r),
        .ex_rd (ex_rd), .mem_wb_en (mem_wb_en), .mem_mem_r (mem_mem_r), .mem_rd (mem_rd),
        .branch_taken (branch_taken), .jump_taken (jump_taken), .terminate (terminate),
        .harzard (s_harzard), .pc_en (s_pc_en), .if_id_en (s_if_id_en),
        .if_id_flush (s_if_id_flush), .id_ex_bubble (s_id_ex_bubble), .halted (s_halted),
        .stall_cycles (s_stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are checked mid-cycle; inputs change 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_is_branch = 0;
        ex_wb_en = 0; ex_mem_r = 0; ex_rd = 0;
        mem_wb_en = 0; mem_mem_r = 0; mem_rd = 0;
        branch_taken = 0; jump_taken = 0; terminate = 0;
    endtask

    // lw $2 in EX, ID reads rs=$2
    task automatic load_use();
        idle();
        ex_wb_en = 1; ex_mem_r = 1; ex_rd = 5'd2; id_rs = 5'd2; id_use_rs = 1;
    endtask

    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk(tag, {harzard, pc_en, if_id_en, if_id_flush, id_ex_bubble}, {27'd0, exp});
    endtask

    initial begin
        // Reset with a live hazard on the inputs: outputs must stay in their reset values.
        rst = 1'b1;
        load_use();
        #2;
        chk_ctl("rst_outputs", 5'b01100);
        tick();
        rst = 1'b0;
        idle();
        #2;
        chk("rst_cnt", stall_cycles, 0);
        chk("rst_halted", {31'd0, halted}, 0);
        chk_ctl("idle_run", 5'b01100);

        // 1. load-use: one stall cycle
        tick();
        load_use();
        #2;
        chk_ctl("lu_stall", 5'b10001);
        tick();
        idle();
        mem_wb_en = 1; mem_mem_r = 1; mem_rd = 5'd2; id_rs = 5'd2; id_use_rs = 1;
        #2;
        chk_ctl("lu_release", 5'b01100);
        chk("lu_cnt", stall_cycles, 1);

        // 2. beq $3,$0 behind lw $3: two stalls, then taken branch flushes
        tick();
        idle();
        id_rs = 5'd3; id_rt = 5'd0; id_use_rs = 1; id_use_rt = 1; id_is_branch = 1;
        ex_wb_en = 1; ex_mem_r = 1; ex_rd = 5'd3;
        #2;
        chk_ctl("br_ld_stall1", 5'b10001);
        tick();
        ex_wb_en = 0; ex_mem_r = 0; ex_rd = 0;
        mem_wb_en = 1; mem_mem_r = 1; mem_rd = 5'd3;
        #2;
        chk_ctl("br_ld_stall2", 5'b10001);
        tick();
        mem_wb_en = 1; mem_mem_r = 0; mem_rd = 5'd3;
        branch_taken = 1;
        #2;
        chk_ctl("br_taken_flush", 5'b01110);
        chk("br_cnt", stall_cycles, 3);

        // 3. $0 never matches
        tick();
        idle();
        id_use_rs = 1; id_use_rt = 1; id_is_branch = 1;
        ex_wb_en = 1; ex_mem_r = 1; mem_wb_en = 1; mem_mem_r = 1;
        #2;
        chk_ctl("zero_reg", 5'b01100);
        // ALU producer feeding a non-branch: forwarded, no stall
        tick();
        idle();
        ex_wb_en = 1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1;
        #2;
        chk_ctl("alu_no_stall", 5'b01100);
        // Matching index but source not used
        id_use_rs = 0; ex_mem_r = 1;
        #2;
        chk_ctl("unused_src", 5'b01100);
        // ALU producer feeding a branch on rt: one stall
        tick();
        idle();
        ex_wb_en = 1; ex_rd = 5'd5; id_rt = 5'd5; id_use_rt = 1; id_is_branch = 1;
        #2;
        chk_ctl("alu_br_stall", 5'b10001);
        tick();
        idle();
        jump_taken = 1;
        #2;
        chk_ctl("jump_flush", 5'b01110);
        chk("alu_br_cnt", stall_cycles, 4);

        // 4. terminate under load-use is ignored, then taken
        tick();
        load_use();
        terminate = 1;
        #2;
        chk_ctl("term_stalled", 5'b10001);
        tick();
        idle();
        terminate = 1; branch_taken = 1;
        #2;
        chk_ctl("term_accept", 5'b00110);
        chk("term_not_halted", {31'd0, halted}, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            load_use();
            #2;
            chk_ctl($sformatf("drain%0d", i), 5'b00001);
            chk($sformatf("drain%0d_halted", i), {31'd0, halted}, 0);
        end
        tick();
        idle();
        #2;
        chk("halted", {31'd0, halted}, 1);
        chk_ctl("halt_ctl", 5'b00001);
        tick();
        #2;
        chk("halt_hold", {31'd0, halted}, 1);
        chk("halt_cnt", stall_cycles, 5);

        // 5. reset in the middle of a drain
        rst = 1;
        tick();
        rst = 0;
        terminate = 1;
        #2;
        chk_ctl("term2_accept", 5'b00110);
        tick();
        idle();
        rst = 1;
        #2;
        chk_ctl("rst_in_drain", 5'b01100);
        tick();
        rst = 0;
        #2;
        chk("post_rst_halted", {31'd0, halted}, 0);
        chk("post_rst_cnt", stall_cycles, 0);
        chk_ctl("post_rst_ctl", 5'b01100);
        for (int i = 0; i < 4; i++) tick();
        #2;
        chk("post_rst_stay_run", {31'd0, halted}, 0);
        chk_ctl("post_rst_stay_ctl", 5'b01100);

        // 6. 20 consecutive stalls: 4-bit counter saturates at 15
        load_use();
        for (int i = 0; i < 14; i++) tick();
        #2;
        chk("sat_14", {28'd0, s_stall_cycles}, 14);
        for (int i = 0; i < 6; i++) tick();
        idle();
        #2;
        chk("sat_15", {28'd0, s_stall_cycles}, 15);
        chk("wide_20", stall_cycles, 20);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
